// File: rtl/hqm_iosf_hs_src_fifo.sv
// Source-side feeder for the IOSF level-handshake CDC: buffers producer requests and presents
// them one at a time on val_src/dat_src, with a one-cycle val_src drop between transactions.
module hqm_iosf_hs_src_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TO_W  = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         in_valid_i,
  input  logic [WIDTH-1:0]             in_data_i,
  output logic                         in_ready_o,
  output logic                         val_src_o,
  output logic [WIDTH-1:0]             dat_src_o,
  input  logic                         rdy_src_i,
  input  logic [TO_W-1:0]              cfg_timeout_i,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         idle_o,
  output logic                         timeout_err_o,
  output logic                         proto_err_o
);

  localparam int unsigned AddrW = $clog2(DEPTH);
  localparam int unsigned PtrW  = AddrW + 1;
  localparam int unsigned CntW  = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {StIdle, StReq, StGap} state_e;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_q, wr_d, rd_q, rd_d;
  state_e           state_q, state_d;
  logic [WIDTH-1:0] dat_q, dat_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic             to_err_q, to_err_d;
  logic             proto_err_q, proto_err_d;
  logic             full, empty, push, pop;
  logic [WIDTH-1:0] head;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AddrW] != rd_q[AddrW]) && (wr_q[AddrW-1:0] == rd_q[AddrW-1:0]);
  assign push  = in_valid_i & ~full;
  assign pop   = (state_q == StReq) & rdy_src_i;
  // Entering REQ with an empty FIFO means this cycle's push is the new head.
  assign head  = empty ? in_data_i : mem_q[rd_q[AddrW-1:0]];

  always_comb begin
    state_d     = state_q;
    dat_d       = dat_q;
    to_cnt_d    = to_cnt_q;
    wr_d        = push ? wr_q + PtrW'(1) : wr_q;
    rd_d        = pop  ? rd_q + PtrW'(1) : rd_q;
    unique case (state_q)
      StIdle, StGap: begin
        if (!empty || push) begin
          state_d  = StReq;
          dat_d    = head;
          to_cnt_d = '0;
        end else begin
          state_d  = StIdle;
        end
      end
      StReq: begin
        if (to_cnt_q != '1) to_cnt_d = to_cnt_q + TO_W'(1);
        if (rdy_src_i) begin
          state_d = StGap;
          dat_d   = '0;
        end
      end
      default: begin
        state_d = StIdle;
        dat_d   = '0;
      end
    endcase
    to_err_d    = to_err_q | ((state_q == StReq) && (cfg_timeout_i != '0) &&
                              (to_cnt_d == cfg_timeout_i));
    proto_err_d = proto_err_q | (rdy_src_i && (state_q != StReq));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q        <= '0;
      rd_q        <= '0;
      state_q     <= StIdle;
      dat_q       <= '0;
      to_cnt_q    <= '0;
      to_err_q    <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      state_q     <= state_d;
      dat_q       <= dat_d;
      to_cnt_q    <= to_cnt_d;
      to_err_q    <= to_err_d;
      proto_err_q <= proto_err_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_q[AddrW-1:0]] <= in_data_i;
  end

  assign in_ready_o    = ~full;
  assign val_src_o     = (state_q == StReq);
  assign dat_src_o     = dat_q;
  assign count_o       = CntW'(wr_q - rd_q);
  assign idle_o        = (state_q == StIdle) && empty;
  assign timeout_err_o = to_err_q;
  assign proto_err_o   = proto_err_q;

endmodule
